// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Up-counter with synchronous clear and enable; tc flags the count equal to LIMIT.
module iter_counter #(
  parameter int CW    = 4,
  parameter int LIMIT = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);
  localparam logic [CW-1:0] ONE_V   = CW'(1);

  logic [CW-1:0] cnt_r;

  // Iteration count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + ONE_V;
    end
  end

  assign tc = (cnt_r == LIMIT_V);

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add unsigned multiplier with start/done handshake.
// Optional ZERO_SKIP_EN: a zero operand completes at the accepting edge.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("seq_mult: WIDTH out of range");
  end

  state_t               state_r;
  logic [WIDTH-1:0]     m_r;
  logic [WIDTH:0]       r_r;
  logic [WIDTH-1:0]     q_r;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;

  logic                 accept_s;
  logic                 step_s;
  logic                 last_s;
  logic                 skip_s;
  logic [WIDTH:0]       sum_s;

  assign accept_s = (state_r == IDLE) && start;
  assign step_s   = (state_r == STEP);

`ifdef ZERO_SKIP_EN
  assign skip_s = (a == '0) || (b == '0);
`else
  assign skip_s = 1'b0;
`endif

  iter_counter #(
    .CW    (CNT_W),
    .LIMIT (WIDTH - 1)
  ) u_iter_counter (
    .clk (clk),
    .rst (rst),
    .clr (accept_s),
    .en  (step_s),
    .tc  (last_s)
  );

  // Conditional add of the multiplicand; R's top bit absorbs the carry.
  always_comb begin
    sum_s = r_r;
    if (q_r[0]) begin
      sum_s = r_r + {1'b0, m_r};
    end else begin
      sum_s = r_r;
    end
  end

  // Control FSM, datapath registers and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      m_r       <= '0;
      r_r       <= '0;
      q_r       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && skip_s) begin
            product_r <= '0;
            done_r    <= 1'b1;
          end else if (start) begin
            m_r     <= a;
            q_r     <= b;
            r_r     <= '0;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= STEP;
          end
        end
        STEP: begin
          // {R,Q} shifts right by one after the add; the product is taken post-shift.
          r_r <= {1'b0, sum_s[WIDTH:1]};
          q_r <= {sum_s[0], q_r[WIDTH-1:1]};
          if (last_s) begin
            product_r <= {sum_s, q_r[WIDTH-1:1]};
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: randomized operations against a plain a*b model.
module tb_seq_mult;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [PW-1:0] product;

  logic          start2, busy2, done2;
  logic [1:0]    a2, b2;
  logic [3:0]    product2;

  logic          start16, busy16, done16;
  logic [15:0]   a16, b16;
  logic [31:0]   product16;

  seq_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  seq_mult #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .product(product2)
  );

  seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(product16)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] prod;
    int            t;
    int            nbusy;
    bit            skip;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the expected result when it falls due and checks busy/done/product.
  initial begin : monitor
    logic          done_prev;
    int            busy_cnt;
    logic [PW-1:0] last_prod;
    exp_t          e;
    done_prev = 1'b0;
    busy_cnt  = 0;
    last_prod = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        done_prev = 1'b0;
        busy_cnt  = 0;
        last_prod = '0;
      end else begin
        if (busy) begin
          busy_cnt++;
          check("product_hold", product, last_prod);
        end
        if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
          e = exp_q.pop_front();
          check("done", done, 1);
          check("product", product, e.prod);
          check("busy_low_at_done", busy, 0);
          check("busy_cycles", busy_cnt, e.nbusy);
          if (!e.skip) check("done_cleared_before", done_prev, 0);
          last_prod = e.prod;
          busy_cnt  = 0;
        end else if (done && !done_prev) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done rose at cycle %0d with no result due, product %0d", cyc, product);
        end
        done_prev = done;
      end
    end
  end

  // Issue one operation at the current negedge; ignored start pulses are thrown in while busy.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t e;
    bit   skip;
    skip = 1'b0;
`ifdef ZERO_SKIP_EN
    skip = (xa == '0) || (xb == '0);
`endif
    start   = 1'b1;
    a       = xa;
    b       = xb;
    e.prod  = PW'(xa) * PW'(xb);
    e.t     = cyc + (skip ? 1 : W + 1);
    e.nbusy = skip ? 0 : W;
    e.skip  = skip;
    exp_q.push_back(e);
    if (skip) begin
      @(negedge clk);
    end else begin
      for (int j = 0; j < W + 1; j++) begin
        @(negedge clk);
        if (j < W) begin
          start = 1'($urandom_range(0, 1));
          a     = W'($urandom);
          b     = W'($urandom);
        end
      end
    end
  endtask

  initial begin : stimulus
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;

    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'd13, 8'd11);
    start = 1'b0;
    @(negedge clk);
    do_op(8'd255, 8'd255);
    start = 1'b0;
    @(negedge clk);

    // Back-to-back with start held high.
    do_op(8'd3, 8'd5);
    do_op(8'd7, 8'd9);
    start = 1'b0;
    @(negedge clk);

    // Reset after four steps of 200x100; the operation is discarded.
    start = 1'b1; a = 8'd200; b = 8'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    check("async_reset_product", product, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd2, 8'd2);
    start = 1'b0;
    @(negedge clk);

    do_op(8'd0, 8'd77);
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      do_op(ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    start = 1'b0;

    // Other widths: 3x3 at WIDTH=2, 40000x3 at WIDTH=16.
    @(negedge clk);
    start2 = 1'b1; a2 = 2'd3; b2 = 2'd3;
    start16 = 1'b1; a16 = 16'd40000; b16 = 16'd3;
    @(negedge clk);
    start2 = 1'b0; a2 = 2'd1; b2 = 2'd2;
    start16 = 1'b0; a16 = 16'd7; b16 = 16'd9;
    @(negedge clk);
    check("w2_done_early", done2, 0);
    @(negedge clk);
    check("w2_done", done2, 1);
    check("w2_product", product2, 9);
    check("w2_busy", busy2, 0);
    repeat (13) @(negedge clk);
    check("w16_done_early", done16, 0);
    @(negedge clk);
    check("w16_done", done16, 1);
    check("w16_product", product16, 120000);
    check("w16_busy", busy16, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier with an embedded iteration counter and start/done handshake. Accepts two unsigned WIDTH-bit operands, computes the 2·WIDTH-bit product in one add/shift step per multiplier bit, and holds the result until the next accepted start. Sits beside the ALU in the CA1 datapath as its multi-cycle multiply unit. It replaces the fixed 4-bit counter/controller pair with a single configurable block.

## Interface

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  multiplicand, unsigned; sampled with accepted start.
- b  in  WIDTH  multiplier, unsigned; sampled with accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  high from completion until the next accepted start.
- product  out  2·WIDTH  last completed result.

## Operation

- Registers:
  - M (WIDTH): multiplicand.
  - R (WIDTH+1): accumulator with carry bit.
  - Q (WIDTH): multiplier/low product.
  - cnt: iteration counter, CNT_W = clog2(WIDTH+1) bits.
  - product_q (2·WIDTH): output register.
- FSM states: IDLE, STEP.
  - IDLE: busy=0. On start=1: M←a, Q←b, R←0, cnt←0, done←0, next state STEP.
  - STEP: busy=1. Each edge:
    - if Q[0]=1 then R←R+M (carry kept in R[WIDTH]).
    - shift {R,Q} right by one; zero enters R's MSB.
    - cnt←cnt+1.
    - when cnt reaches WIDTH−1 on this edge: product_q←{R,Q} after the step, done←1, next state IDLE.
- Arithmetic: unsigned only; the product never overflows 2·WIDTH bits.
- start while busy=1: ignored. a and b may change freely during STEP.
- start held high in IDLE: a new operation is accepted on that edge. done is high for exactly one cycle between back-to-back operations.
- product is unchanged from acceptance until completion, so it shows the previous result during STEP.
- Reset (any time, including mid-STEP): state IDLE, busy=0, done=0, product=0, M/R/Q/cnt=0. An operation interrupted by reset is discarded and is not resumed.

## Timing

- Edge E0 samples start in IDLE. Edges E1..E_WIDTH perform the steps.
- After E_WIDTH: done=1, busy=0, product valid.
- Latency: WIDTH+1 edges from the start sample to done=1. busy is high for exactly WIDTH cycles.
- Throughput: one result per WIDTH+1 cycles with start held high.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- ZERO_SKIP_EN defined:
  - at E0, if a=0 or b=0, the block stays in IDLE and sets product←0, done←1 (clearing the old done is superseded).
  - done is therefore visible after E0 (latency 1); busy never rises.
- Not defined: zero operands take the full WIDTH+1 edge latency, with product=0.

## Structure

- Package mult_pkg:
  - state typedef (IDLE, STEP).
  - function clog2 for CNT_W.
  - constants WIDTH_MIN=2, WIDTH_MAX=32.
- Sub-module iter_counter:
  - parametrised up-counter with synchronous clear, enable, and a terminal-count output for a given LIMIT.
  - instantiated with LIMIT=WIDTH−1; drives the STEP→IDLE transition.
- All remaining logic (FSM, datapath registers, product_q) sits in seq_mult.

## Test plan

All scenarios use WIDTH=8 unless stated.
- 13×11 → product=143 and done=1 exactly 9 edges after the start sample; busy high for 8 cycles.
- 255×255 → product=65025, exercising the accumulator carry.
- Back-to-back with start held high, 3×5 followed by 7×9 (operands switched while busy) → results 15 then 63; done high for one cycle between them; busy toggles as specified.
- Start pulse mid-operation with different operands → ignored; the original product is returned at the original time.
- Reset asserted at step 4 of 200×100 → busy=0, done=0, product=0 immediately (async). A subsequent 2×2 → 4 with normal latency.
- Zero operand, 0×77:
  - with ZERO_SKIP_EN: done after 1 edge, product=0, busy stays 0.
  - without ZERO_SKIP_EN: done after 9 edges, product=0.
  - Repeat the 13×11 case at WIDTH=2 and WIDTH=16 (3×3=9; 40000×3=120000) to check parametrisation.
